// File: rtl/frame_crc_inserter.sv
// Frame CRC inserter: passes bytes through with one clock of latency, replaces the
// flagged CRC byte with a running CRC-8 (poly 0x07) and checks SOP/payload/CRC/EOP framing.
module frame_crc_inserter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       is_control_byte,
  input  logic       is_crc_byte,
  input  logic       crc_reset,
  output logic [7:0] tx_data,
  output logic       tx_is_k,
  output logic       frame_done,
  output logic       frame_error,
  output logic [7:0] error_count
);

  // state    | meaning
  // HUNT     | waiting for SOP
  // PAYLOAD  | counting payload bytes
  // WAIT_EOP | CRC seen, EOP expected
  typedef enum logic [1:0] {HUNT, PAYLOAD, WAIT_EOP} state_t;

  localparam logic [7:0] SOP_CHAR = 8'h3C;
  localparam logic [7:0] EOP_CHAR = 8'hBC;
  localparam logic [3:0] GOOD_LEN = 4'd7;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_is_k_q;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] ecnt_q, ecnt_d;
  logic       is_sop, is_eop;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign is_sop = is_control_byte && (data == SOP_CHAR);
  assign is_eop = is_control_byte && (data == EOP_CHAR);

  always_comb begin
    acc_d     = acc_q;
    tx_data_d = is_crc_byte ? acc_q : data;
    if (crc_reset) begin
      acc_d = 8'h00;
    end else if (!is_control_byte && !is_crc_byte) begin
      acc_d = crc8_step(acc_q, data);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    if (is_crc_byte && (is_control_byte || crc_reset)) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end else if (is_control_byte && !is_sop && !is_eop) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end else if (crc_reset && !is_sop) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end else if (is_sop) begin
      // An SOP without crc_reset cannot start a frame, so it is treated as malformed.
      if (!crc_reset) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else begin
        err_d   = (state_q != HUNT);
        state_d = PAYLOAD;
        cnt_d   = 4'd0;
      end
    end else if (is_eop) begin
      if (state_q == WAIT_EOP) begin
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d = HUNT;
    end else if (is_crc_byte) begin
      unique case (state_q)
        PAYLOAD: begin
          err_d   = (cnt_q != GOOD_LEN);
          state_d = WAIT_EOP;
        end
        WAIT_EOP: begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
        default: ;
      endcase
    end else begin
      unique case (state_q)
        PAYLOAD: begin
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
        WAIT_EOP: begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      cnt_q     <= 4'd0;
      acc_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_is_k_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ecnt_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tx_data_q <= tx_data_d;
      tx_is_k_q <= is_control_byte;
      done_q    <= done_d;
      err_q     <= err_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_is_k     = tx_is_k_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign error_count = ecnt_q;

endmodule

// File: tb/tb_frame_crc_inserter.sv
// Bench for frame_crc_inserter: directed frames plus random traffic, each byte checked
// against a frame-level reference model that recomputes the CRC from the stored payload.
module tb_frame_crc_inserter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       is_control_byte = 1'b0;
  logic       is_crc_byte = 1'b0;
  logic       crc_reset = 1'b0;
  logic [7:0] tx_data;
  logic       tx_is_k;
  logic       frame_done;
  logic       frame_error;
  logic [7:0] error_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int         ph = 0;          // 0 hunt, 1 in payload, 2 awaiting EOP
  int         npay = 0;
  int         ecnt = 0;
  logic [7:0] pl[$];
  int         done_cyc[$];
  logic [7:0] last_crc_tx = 8'h00;
  int         last_k_count = 0;

  frame_crc_inserter dut (
    .clk(clk), .reset(reset), .data(data), .is_control_byte(is_control_byte),
    .is_crc_byte(is_crc_byte), .crc_reset(crc_reset), .tx_data(tx_data),
    .tx_is_k(tx_is_k), .frame_done(frame_done), .frame_error(frame_error),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_of_payload();
    logic [7:0] c = 8'h00;
    foreach (pl[i]) begin
      c = c ^ pl[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic model_reset();
    ph = 0; npay = 0; ecnt = 0; pl.delete();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %02h expected %02h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic k, input logic c, input logic r);
    logic [7:0] e_data;
    logic       e_done, e_err;
    string      kind;
    e_done = 1'b0; e_err = 1'b0;
    e_data = c ? crc_of_payload() : d;
    if (c && (k || r))                 kind = "bad";
    else if (k && d == 8'h3C && r)     kind = "sop";
    else if (k && d == 8'hBC && !r)    kind = "eop";
    else if (k || r)                   kind = "bad";
    else if (c)                        kind = "crc";
    else                               kind = "pay";
    case (kind)
      "bad": begin e_err = 1; ph = 0; end
      "sop": begin e_err = (ph != 0); ph = 1; npay = 0; end
      "eop": begin e_done = (ph == 2); e_err = (ph != 2); ph = 0; end
      "crc": begin
        if (ph == 1) begin e_err = (npay != 7); ph = 2; end
        else if (ph == 2) begin e_err = 1; ph = 0; end
      end
      default: begin
        if (ph == 1) npay = (npay < 15) ? npay + 1 : 15;
        else if (ph == 2) begin e_err = 1; ph = 0; end
      end
    endcase
    if (e_err && ecnt < 255) ecnt++;
    if (r) pl.delete();
    else if (!k && !c) pl.push_back(d);

    @(negedge clk);
    data = d; is_control_byte = k; is_crc_byte = c; crc_reset = r;
    @(posedge clk);
    #1;
    cyc++;
    chk("tx_data", tx_data, e_data);
    chk("tx_is_k", {7'd0, tx_is_k}, {7'd0, k});
    chk("frame_done", {7'd0, frame_done}, {7'd0, e_done});
    chk("frame_error", {7'd0, frame_error}, {7'd0, e_err});
    chk("error_count", error_count, ecnt[7:0]);
    if (frame_done) done_cyc.push_back(cyc);
    if (c) last_crc_tx = tx_data;
    if (tx_is_k) last_k_count++;
  endtask

  task automatic frame(input logic [7:0] p[], input logic [7:0] crc_ph);
    step(8'h3C, 1, 0, 1);
    foreach (p[i]) step(p[i], 0, 0, 0);
    step(crc_ph, 0, 1, 0);
    step(8'hBC, 1, 0, 0);
  endtask

  initial begin
    logic [7:0] idle[] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] trig[] = '{8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] shrt[] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rp[];

    #3;
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_flags", {5'd0, tx_is_k, frame_done, frame_error}, 8'h00);
    chk("reset_error_count", error_count, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // idle frame
    frame(idle, 8'h00);
    chk("idle_crc", last_crc_tx, 8'h00);
    chk("idle_errcnt", error_count, 8'h00);

    // trigger frame, input CRC byte value must be overwritten
    last_k_count = 0;
    frame(trig, 8'hA5);
    chk("trigger_crc", last_crc_tx, 8'h4F);
    chk("trigger_k_count", last_k_count[7:0], 8'd2);

    // back-to-back trigger then idle
    done_cyc.delete();
    frame(trig, 8'h11);
    chk("b2b_crc1", last_crc_tx, 8'h4F);
    frame(idle, 8'h22);
    chk("b2b_crc2", last_crc_tx, 8'h00);
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_done_gap", done_cyc[1] - done_cyc[0], 10);

    // short frame
    frame(shrt, 8'h00);
    chk("short_errcnt", error_count, 8'h01);

    // aborted frame followed by a full idle frame
    step(8'h3C, 1, 0, 1);
    step(8'h12, 0, 0, 0); step(8'h34, 0, 0, 0); step(8'h56, 0, 0, 0);
    frame(idle, 8'h77);
    chk("abort_crc", last_crc_tx, 8'h00);
    chk("abort_errcnt", error_count, 8'h02);

    // reset mid-payload
    step(8'h3C, 1, 0, 1);
    step(8'h08, 0, 0, 0); step(8'h99, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_flags", {5'd0, tx_is_k, frame_done, frame_error}, 8'h00);
    chk("midrst_errcnt", error_count, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    frame(trig, 8'h00);
    chk("post_reset_crc", last_crc_tx, 8'h4F);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 5);
      if (kind <= 2) begin
        rp = new[7];
        foreach (rp[i]) rp[i] = 8'($urandom);
        frame(rp, 8'($urandom));
      end else if (kind == 3) begin
        rp = new[$urandom_range(0, 17)];
        foreach (rp[i]) rp[i] = 8'($urandom);
        frame(rp, 8'($urandom));
      end else if (kind == 4) begin
        logic [3:0] f = 4'($urandom);
        logic [7:0] d = ($urandom_range(0, 1) == 1) ? 8'h3C : (($urandom_range(0, 1) == 1) ? 8'hBC : 8'($urandom));
        step(d, f[0] | f[3], f[1] & f[2], f[2] & ~f[1] & f[3]);
      end else begin
        step(8'($urandom), 0, 0, 0);
      end
    end

    // error counter saturation
    for (int n = 0; n < 300; n++) step(8'h55, 1, 0, 0);
    chk("errcnt_saturated", error_count, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
